// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the banked register file: clear-FSM states,
// write-class priority ordering and range/width helpers.
package reg_file_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} clr_state_t;

  // Write classes in ascending priority; later classes overwrite earlier ones.
  localparam int PRIO_ASG    = 0;
  localparam int PRIO_ALU    = 1;
  localparam int PRIO_LS     = 2;
  localparam int NUM_CLASSES = 3;

  function automatic logic in_lim(input logic [31:0] v, input logic [31:0] lim);
    return v < lim;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_clear_seq.sv
// Background bank-clear sequencer: walks every register of one latched bank,
// one per cycle, then pulses done for a single cycle.
module bank_clear_seq
  import reg_file_pkg::*;
#(
  parameter int REGS_PER_BANK = 32,
  parameter int NUM_BANKS     = 4,
  parameter int AW            = clog2_min1(REGS_PER_BANK),
  parameter int BW            = clog2_min1(NUM_BANKS)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          clr_req_i,
  input  logic [BW-1:0] clr_bank_i,
  output logic          clear_en,
  output logic [AW-1:0] clear_idx,
  output logic [BW-1:0] clear_bank,
  output logic          busy,
  output logic          done,
  output logic          bad_req
);

  clr_state_t    state;
  logic [AW-1:0] cnt;
  logic [BW-1:0] bank_q;
  logic          req_ok;

  assign req_ok     = in_lim(32'(clr_bank_i), NUM_BANKS);
  assign clear_en   = (state == CLEAR);
  assign clear_idx  = cnt;
  assign clear_bank = bank_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign bad_req    = (state == IDLE) && clr_req_i && !req_ok;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      cnt    <= '0;
      bank_q <= '0;
    end else begin
      case (state)
        IDLE: if (clr_req_i && req_ok) begin
          state  <= CLEAR;
          cnt    <= '0;
          bank_q <= clr_bank_i;
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(REGS_PER_BANK - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/banked_reg_file.sv
// Multi-lane, multi-bank register file with prioritised writeback, same-cycle
// write-through bypass on reads and a background bank-clear sequencer.
module banked_reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int REGS_PER_BANK = 32,
  parameter int NUM_BANKS     = 4,
  parameter int NUM_LANES     = 2,
  parameter int AW            = clog2_min1(REGS_PER_BANK),
  parameter int BW            = clog2_min1(NUM_BANKS)
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [BW-1:0]                     bank_sel_i,
  input  logic [NUM_LANES-1:0]              wr_en_i,
  input  logic [NUM_LANES-1:0][AW-1:0]      wr_addr_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]  wr_data_i,
  input  logic [NUM_LANES-1:0][1:0]         wr_stat_i,
  input  logic [NUM_LANES-1:0]              ls_en_i,
  input  logic [NUM_LANES-1:0][AW-1:0]      ls_addr_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]  ls_data_i,
  input  logic [NUM_LANES-1:0]              asg_en_i,
  input  logic [NUM_LANES-1:0][AW-1:0]      asg_addr_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]  asg_src_i,
  input  logic [NUM_LANES-1:0]              asg_isreg_i,
  input  logic [NUM_LANES-1:0]              rd1_en_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]  rd1_addr_i,
  input  logic [NUM_LANES-1:0]              rd2_en_i,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]  rd2_addr_i,
  output logic [NUM_LANES-1:0][DATA_W-1:0]  rd1_data_o,
  output logic [NUM_LANES-1:0][DATA_W-1:0]  rd2_data_o,
  output logic [NUM_LANES-1:0][1:0]         stat_o,
  input  logic                              clr_req_i,
  input  logic [BW-1:0]                     clr_bank_i,
  output logic                              clr_busy_o,
  output logic                              clr_done_o,
  output logic                              drop_err_o
);

  localparam int NREG = NUM_BANKS * REGS_PER_BANK;
  localparam int PW   = clog2_min1(NREG);
  localparam int NC   = NUM_CLASSES * NUM_LANES;

  function automatic logic [PW-1:0] phys(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return PW'(int'(b) * REGS_PER_BANK + int'(a));
  endfunction

  logic [DATA_W-1:0]          mem [NREG];
  logic                       bank_ok, blocked;
  logic                       clr_en, clr_bad;
  logic [AW-1:0]              clr_idx;
  logic [BW-1:0]              clr_bank;
  logic [NC-1:0]              cand_req, cand_vld;
  logic [NC-1:0][AW-1:0]      cand_addr;
  logic [NC-1:0][PW-1:0]      cand_idx;
  logic [NC-1:0][DATA_W-1:0]  cand_dat;

  bank_clear_seq #(
    .REGS_PER_BANK(REGS_PER_BANK), .NUM_BANKS(NUM_BANKS), .AW(AW), .BW(BW)
  ) u_clr (
    .clock_i(clock_i), .reset_i(reset_i), .clr_req_i(clr_req_i), .clr_bank_i(clr_bank_i),
    .clear_en(clr_en), .clear_idx(clr_idx), .clear_bank(clr_bank),
    .busy(clr_busy_o), .done(clr_done_o), .bad_req(clr_bad)
  );

  // Write candidates laid out in ascending priority: class-major, lane-minor.
  // Reg-reg assign samples the array directly so swaps see pre-cycle values.
  always_comb begin
    cand_req  = '0;
    cand_addr = '0;
    cand_dat  = '0;
    cand_vld  = '0;
    cand_idx  = '0;
    bank_ok   = in_lim(32'(bank_sel_i), NUM_BANKS);
    blocked   = clr_en && (bank_sel_i == clr_bank);
    for (int l = 0; l < NUM_LANES; l++) begin
      cand_req [PRIO_ASG*NUM_LANES+l] = asg_en_i[l];
      cand_addr[PRIO_ASG*NUM_LANES+l] = asg_addr_i[l];
      if (!asg_isreg_i[l])
        cand_dat[PRIO_ASG*NUM_LANES+l] = asg_src_i[l];
      else if (bank_ok && in_lim(32'(asg_src_i[l]), REGS_PER_BANK))
        cand_dat[PRIO_ASG*NUM_LANES+l] = mem[phys(bank_sel_i, asg_src_i[l][AW-1:0])];
      cand_req [PRIO_ALU*NUM_LANES+l] = wr_en_i[l];
      cand_addr[PRIO_ALU*NUM_LANES+l] = wr_addr_i[l];
      cand_dat [PRIO_ALU*NUM_LANES+l] = wr_data_i[l];
      cand_req [PRIO_LS*NUM_LANES+l]  = ls_en_i[l];
      cand_addr[PRIO_LS*NUM_LANES+l]  = ls_addr_i[l];
      cand_dat [PRIO_LS*NUM_LANES+l]  = ls_data_i[l];
    end
    for (int c = 0; c < NC; c++) begin
      cand_vld[c] = cand_req[c] && bank_ok && !blocked &&
                    in_lim(32'(cand_addr[c]), REGS_PER_BANK);
      cand_idx[c] = phys(bank_sel_i, cand_addr[c]);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (clr_en) mem[phys(clr_bank, clr_idx)] <= '0;
      for (int c = 0; c < NC; c++)
        if (cand_vld[c]) mem[cand_idx[c]] <= cand_dat[c];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                           drop_err_o <= 1'b0;
    else if (|(cand_req & ~cand_vld) || clr_bad) drop_err_o <= 1'b1;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int ALU_C = PRIO_ALU * NUM_LANES + l;
    logic [1:0]              en;
    logic [1:0][DATA_W-1:0]  adr, nxt;
    logic [DATA_W-1:0]       rd1_q, rd2_q;
    logic [1:0]              stat_q, stat_out_q;

    assign en  = {rd2_en_i[l], rd1_en_i[l]};
    assign adr = {rd2_addr_i[l], rd1_addr_i[l]};

    // Disabled port passes the address bus through as an immediate.
    always_comb begin
      nxt = '0;
      for (int p = 0; p < 2; p++) begin
        if (!en[p]) begin
          nxt[p] = adr[p];
        end else if (bank_ok && in_lim(32'(adr[p]), REGS_PER_BANK)) begin
          nxt[p] = mem[phys(bank_sel_i, adr[p][AW-1:0])];
          for (int c = 0; c < NC; c++)
            if (cand_vld[c] && cand_idx[c] == phys(bank_sel_i, adr[p][AW-1:0]))
              nxt[p] = cand_dat[c];
        end
      end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        rd1_q      <= '0;
        rd2_q      <= '0;
        stat_q     <= '0;
        stat_out_q <= '0;
      end else begin
        rd1_q <= nxt[0];
        rd2_q <= nxt[1];
        if (cand_vld[ALU_C]) stat_q <= wr_stat_i[l];
        if (rd1_en_i[l]) stat_out_q <= cand_vld[ALU_C] ? wr_stat_i[l] : stat_q;
      end
    end

    assign rd1_data_o[l] = rd1_q;
    assign rd2_data_o[l] = rd2_q;
    assign stat_o[l]     = stat_out_q;
  end

endmodule

// File: tb/tb_banked_reg_file.sv
// Directed bench for banked_reg_file: priority, bypass, swap, immediates,
// range handling and the bank-clear sequencer including reset mid-clear.
module tb_banked_reg_file;
  localparam int DW = 16, RPB = 32, NB = 4, NL = 2, AW = 5, BW = 2;

  logic clock_i = 1'b0;
  logic reset_i;
  always #5 clock_i = ~clock_i;

  logic [BW-1:0]              bank_sel_i, clr_bank_i;
  logic [NL-1:0]              wr_en_i, ls_en_i, asg_en_i, asg_isreg_i, rd1_en_i, rd2_en_i;
  logic [NL-1:0][AW-1:0]      wr_addr_i, ls_addr_i, asg_addr_i;
  logic [NL-1:0][DW-1:0]      wr_data_i, ls_data_i, asg_src_i, rd1_addr_i, rd2_addr_i;
  logic [NL-1:0][DW-1:0]      rd1_data_o, rd2_data_o;
  logic [NL-1:0][1:0]         wr_stat_i, stat_o;
  logic                       clr_req_i, clr_busy_o, clr_done_o, drop_err_o;

  int n_chk = 0, n_err = 0;

  banked_reg_file #(.DATA_W(DW), .REGS_PER_BANK(RPB), .NUM_BANKS(NB), .NUM_LANES(NL)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .bank_sel_i(bank_sel_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_stat_i(wr_stat_i),
    .ls_en_i(ls_en_i), .ls_addr_i(ls_addr_i), .ls_data_i(ls_data_i),
    .asg_en_i(asg_en_i), .asg_addr_i(asg_addr_i), .asg_src_i(asg_src_i), .asg_isreg_i(asg_isreg_i),
    .rd1_en_i(rd1_en_i), .rd1_addr_i(rd1_addr_i), .rd2_en_i(rd2_en_i), .rd2_addr_i(rd2_addr_i),
    .rd1_data_o(rd1_data_o), .rd2_data_o(rd2_data_o), .stat_o(stat_o),
    .clr_req_i(clr_req_i), .clr_bank_i(clr_bank_i), .clr_busy_o(clr_busy_o),
    .clr_done_o(clr_done_o), .drop_err_o(drop_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bank_sel_i = '0; clr_bank_i = '0; clr_req_i = 1'b0;
    wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0; wr_stat_i = '0;
    ls_en_i = '0; ls_addr_i = '0; ls_data_i = '0;
    asg_en_i = '0; asg_addr_i = '0; asg_src_i = '0; asg_isreg_i = '0;
    rd1_en_i = '0; rd1_addr_i = '0; rd2_en_i = '0; rd2_addr_i = '0;
  endtask

  // All tasks start and end on a falling edge.
  task automatic rd1(input int l, input int b, input int a, output logic [DW-1:0] d);
    bank_sel_i = BW'(b); rd1_en_i[l] = 1'b1; rd1_addr_i[l] = DW'(a);
    @(negedge clock_i);
    d = rd1_data_o[l];
    idle_in();
  endtask

  task automatic wr_alu(input int b, input int a, input logic [DW-1:0] v);
    bank_sel_i = BW'(b); wr_en_i[0] = 1'b1; wr_addr_i[0] = AW'(a); wr_data_i[0] = v;
    @(negedge clock_i);
    idle_in();
  endtask

  task automatic run_clear(input int b, input bit inject,
                           output int busy_n, output int done_k, output int n_done);
    busy_n = 0; done_k = 0; n_done = 0;
    clr_req_i = 1'b1; clr_bank_i = BW'(b);
    @(negedge clock_i);
    clr_req_i = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (!clr_busy_o) break;
      busy_n++;
      if (clr_done_o) begin n_done++; if (done_k == 0) done_k = k; end
      idle_in();
      if (inject && k == 5) begin
        bank_sel_i = 2'd2; wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd2; wr_data_i[0] = 16'h1234;
      end
      if (inject && k == 6) begin
        bank_sel_i = 2'd1; wr_en_i[1] = 1'b1; wr_addr_i[1] = 5'd9; wr_data_i[1] = 16'h0909;
      end
      @(negedge clock_i);
    end
    idle_in();
  endtask

  initial begin
    logic [DW-1:0] d;
    int bn, dk, nd, nz;
    idle_in();
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    check("rst_rd1", rd1_data_o, 0);
    check("rst_stat", stat_o, 0);
    check("rst_busy", clr_busy_o, 0);
    check("rst_drop", drop_err_o, 0);
    reset_i = 1'b0;
    @(negedge clock_i);

    rd1(0, 0, 5, d);
    check("rd_b0_r5", d, 0);
    check("stat_after_rd", stat_o[0], 0);

    // ALU A and LS B hit the same reg; LS wins and is bypassed to the reader.
    bank_sel_i = 2'd1;
    wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd3; wr_data_i[0] = 16'h1111; wr_stat_i[0] = 2'b10;
    ls_en_i[1] = 1'b1; ls_addr_i[1] = 5'd3; ls_data_i[1] = 16'h2222;
    rd1_en_i[0] = 1'b1; rd1_addr_i[0] = 16'd3;
    @(negedge clock_i);
    check("bypass_ls_wins", rd1_data_o[0], 16'h2222);
    check("stat_bypass", stat_o[0], 2'b10);
    idle_in();
    rd1(0, 1, 3, d);
    check("ls_wins_stored", d, 16'h2222);

    // Within-class lane priority and ALU over assign.
    bank_sel_i = 2'd1;
    ls_en_i = 2'b11; ls_addr_i[0] = 5'd6; ls_addr_i[1] = 5'd6;
    ls_data_i[0] = 16'h0A0A; ls_data_i[1] = 16'h0B0B;
    wr_en_i[1] = 1'b1; wr_addr_i[1] = 5'd4; wr_data_i[1] = 16'h7777;
    asg_en_i[0] = 1'b1; asg_addr_i[0] = 5'd4; asg_src_i[0] = 16'h1234;
    @(negedge clock_i);
    idle_in();
    rd1(0, 1, 6, d);
    check("ls_lane_b_wins", d, 16'h0B0B);
    rd1(1, 1, 4, d);
    check("alu_beats_asg", d, 16'h7777);

    // Swap through reg-reg assigns.
    bank_sel_i = 2'd0;
    wr_en_i = 2'b11; wr_addr_i[0] = 5'd1; wr_data_i[0] = 16'hAAAA;
    wr_addr_i[1] = 5'd2; wr_data_i[1] = 16'h5555;
    ls_en_i[0] = 1'b1; ls_addr_i[0] = 5'd8; ls_data_i[0] = 16'h0808;
    @(negedge clock_i);
    idle_in();
    asg_en_i = 2'b11; asg_isreg_i = 2'b11;
    asg_addr_i[0] = 5'd1; asg_src_i[0] = 16'd2;
    asg_addr_i[1] = 5'd2; asg_src_i[1] = 16'd1;
    rd1_en_i[0] = 1'b1; rd1_addr_i[0] = 16'd1;
    rd2_en_i[0] = 1'b1; rd2_addr_i[0] = 16'd2;
    @(negedge clock_i);
    check("swap_byp_r1", rd1_data_o[0], 16'h5555);
    check("swap_byp_r2", rd2_data_o[0], 16'hAAAA);
    idle_in();
    rd1(0, 0, 1, d);
    check("swap_r1", d, 16'h5555);
    rd1(1, 0, 2, d);
    check("swap_r2", d, 16'hAAAA);

    // Immediate pass-through and out-of-range read.
    rd2_en_i[0] = 1'b0; rd2_addr_i[0] = 16'h00C3;
    rd1_en_i[0] = 1'b1; rd1_addr_i[0] = 16'd40;
    @(negedge clock_i);
    check("rd2_imm", rd2_data_o[0], 16'h00C3);
    check("rd1_oor", rd1_data_o[0], 0);
    check("drop_clean", drop_err_o, 0);
    idle_in();

    // Preset bank 2, then clear it with writes injected mid-clear.
    for (int r = 0; r < RPB; r += 2) begin
      bank_sel_i = 2'd2; wr_en_i = 2'b11;
      wr_addr_i[0] = AW'(r); wr_addr_i[1] = AW'(r + 1);
      wr_data_i[0] = 16'hFFFF; wr_data_i[1] = 16'hFFFF;
      @(negedge clock_i);
    end
    idle_in();
    rd1(0, 2, 17, d);
    check("preset_b2", d, 16'hFFFF);
    run_clear(2, 1'b1, bn, dk, nd);
    check("clr_busy_cycles", bn, 33);
    check("clr_done_cycle", dk, 33);
    check("clr_done_pulses", nd, 1);
    check("clr_drop_flag", drop_err_o, 1);
    nz = 0;
    for (int r = 0; r < RPB; r++) begin
      rd1(r % 2, 2, r, d);
      if (d != 0) nz++;
    end
    check("clr_b2_nonzero", nz, 0);
    rd1(0, 1, 3, d);
    check("clr_b1_r3", d, 16'h2222);
    rd1(0, 1, 9, d);
    check("clr_b1_r9", d, 16'h0909);

    // Reset in the middle of a clear.
    wr_alu(3, 0, 16'h3333);
    clr_req_i = 1'b1; clr_bank_i = 2'd2;
    @(negedge clock_i);
    idle_in();
    repeat (9) @(negedge clock_i);
    check("mid_busy", clr_busy_o, 1);
    reset_i = 1'b1;
    #1;
    check("rst_mid_busy", clr_busy_o, 0);
    check("rst_mid_done", clr_done_o, 0);
    check("rst_mid_drop", drop_err_o, 0);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    rd1(0, 3, 0, d);
    check("rst_zeroed", d, 0);
    run_clear(0, 1'b0, bn, dk, nd);
    check("clr2_busy_cycles", bn, 33);
    check("clr2_done_pulses", nd, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
